// File: rtl/writeback_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : writeback_arbiter
//  Description : Shares the register-file write port between the single-cycle
//                datapath (A, priority) and memory load returns (B, buffered
//                in a small FIFO with a starvation guard). Exports a mask of
//                registers with queued loads for RAW hazard stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
    parameter int WORD       = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_reg,
    input  logic [WORD-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_reg,
    input  logic [WORD-1:0] b_data,
    output logic            rf_we,
    output logic [4:0]      rf_addr,
    output logic [WORD-1:0] rf_data,
    output logic [31:0]     pending_mask
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_st_w  = $clog2(MAX_WAIT + 1);

    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_st_w-1:0]  c_max_wait = c_st_w'(MAX_WAIT);
    localparam logic [4:0]         c_xzr      = 5'd31;

    // B buffer storage and bookkeeping
    logic [4:0]         r_reg_mem  [FIFO_DEPTH];
    logic [WORD-1:0]    r_data_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_st_w-1:0]  r_starve;

    logic               w_b_avail;
    logic               w_forced;
    logic               w_grant_a;
    logic               w_grant_b;
    logic               w_push;
    logic               w_pop;
    logic [4:0]         w_gnt_reg;
    logic [WORD-1:0]    w_gnt_data;
    logic [c_ptr_w-1:0] w_off   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] w_entry_valid;

    // Arbitration: A wins unless the B head has lost MAX_WAIT times in a row
    assign w_b_avail = (r_count != '0);
    assign w_forced  = a_valid && w_b_avail && (r_starve == c_max_wait);
    assign w_grant_a = !reset && a_valid && !w_forced;
    assign w_grant_b = !reset && w_b_avail && (!a_valid || w_forced);

    assign a_ready = w_grant_a;
    // Decoded from the registered count so a same-cycle pop never opens a full FIFO
    assign b_ready = !reset && (r_count != c_full);

    assign w_push = b_valid && b_ready;
    assign w_pop  = w_grant_b;

    assign w_gnt_reg  = w_grant_a ? a_reg  : r_reg_mem[r_rd_ptr];
    assign w_gnt_data = w_grant_a ? a_data : r_data_mem[r_rd_ptr];

    // An entry is live when its distance from the read pointer is below count
    generate
        for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_entry
            assign w_off[i]         = c_ptr_w'(i) - r_rd_ptr;
            assign w_entry_valid[i] = ({1'b0, w_off[i]} < r_count);
        end
    endgenerate

    // Hazard mask: one bit per register targeted by a queued load (XZR never stalls)
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_entry_valid[i] && (r_reg_mem[i] != c_xzr)) begin
                pending_mask[r_reg_mem[i]] = 1'b1;
            end
        end
    end

    // FIFO payload; no reset needed since validity is tracked by count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reg_mem[r_wr_ptr]  <= b_reg;
            r_data_mem[r_wr_ptr] <= b_data;
        end
    end

    // FIFO pointers, occupancy and the starvation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + {{c_ptr_w{1'b0}}, w_push} - {{c_ptr_w{1'b0}}, w_pop};
            if (!w_b_avail || w_grant_b) begin
                r_starve <= '0;
            end else if (a_valid && (r_starve != c_max_wait)) begin
                r_starve <= r_starve + c_st_w'(1);
            end
        end
    end

    // Registered write port; XZR grants are consumed without a write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else if ((w_grant_a || w_grant_b) && (w_gnt_reg != c_xzr)) begin
            rf_we   <= 1'b1;
            rf_addr <= w_gnt_reg;
            rf_data <= w_gnt_data;
        end else begin
            rf_we   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_arbiter
//  Description : Directed scenarios plus randomized traffic against a
//                queue-based model of the writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;

    localparam int WORD       = 64;
    localparam int FIFO_DEPTH = 2;
    localparam int MAX_WAIT   = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            a_valid = 1'b0;
    logic            a_ready;
    logic [4:0]      a_reg = '0;
    logic [WORD-1:0] a_data = '0;
    logic            b_valid = 1'b0;
    logic            b_ready;
    logic [4:0]      b_reg = '0;
    logic [WORD-1:0] b_data = '0;
    logic            rf_we;
    logic [4:0]      rf_addr;
    logic [WORD-1:0] rf_data;
    logic [31:0]     pending_mask;

    writeback_arbiter #(
        .WORD(WORD), .FIFO_DEPTH(FIFO_DEPTH), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [4:0] r; logic [WORD-1:0] d; } entry_t;
    entry_t          m_q[$];
    int              m_starve = 0;
    logic            e_we = 1'b0;
    logic [4:0]      e_addr = '0;
    logic [WORD-1:0] e_data = '0;
    logic            m_grant_a = 1'b0;

    always @(negedge clk) begin
        logic [31:0] emask;
        bit both, forced, ga, gb, push;
        int nb;
        entry_t ent;
        if (reset) begin
            m_q.delete();
            m_starve = 0;
            e_we = 1'b0; e_addr = '0; e_data = '0;
        end
        chk("rf_we", rf_we, e_we);
        chk("rf_addr", rf_addr, e_addr);
        chk("rf_data", rf_data, e_data);
        emask = '0;
        foreach (m_q[i]) if (m_q[i].r != 5'd31) emask = emask | (32'd1 << m_q[i].r);
        chk("pending_mask", pending_mask, emask);
        if (reset) begin
            chk("a_ready_rst", a_ready, 0);
            chk("b_ready_rst", b_ready, 0);
            m_grant_a = 1'b0;
        end else begin
            nb     = m_q.size();
            both   = a_valid && nb > 0;
            forced = both && m_starve == MAX_WAIT;
            ga     = a_valid && !forced;
            gb     = !ga && nb > 0;
            push   = b_valid && nb < FIFO_DEPTH;
            chk("a_ready", a_ready, ga);
            chk("b_ready", b_ready, nb < FIFO_DEPTH);
            e_we = 1'b0;
            if (ga) begin
                ent.r = a_reg; ent.d = a_data;
            end else if (gb) begin
                ent = m_q.pop_front();
            end
            if ((ga || gb) && ent.r != 5'd31) begin
                e_we = 1'b1; e_addr = ent.r; e_data = ent.d;
            end
            if (nb == 0 || gb) m_starve = 0;
            else if (both && m_starve < MAX_WAIT) m_starve++;
            if (push) begin
                ent.r = b_reg; ent.d = b_data;
                m_q.push_back(ent);
            end
            m_grant_a = ga;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic av, input logic [4:0] ar, input logic [WORD-1:0] ad,
                        input logic bv, input logic [4:0] br, input logic [WORD-1:0] bd);
        @(posedge clk); #1;
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_b_ready", b_ready, 1);

        // single A write
        step(1, 3, 64'h55, 0, 0, 0);   chk("t1_a_ready", a_ready, 1);
        idle();                        chk("t1_we", rf_we, 1);
        chk("t1_addr", rf_addr, 3);    chk("t1_data", rf_data, 64'h55);
        idle();                        chk("t1_we_off", rf_we, 0);

        // single B load return
        step(0, 0, 0, 1, 7, 64'hABCD); chk("t2_mask0", pending_mask, 0);
        idle();                        chk("t2_mask7", pending_mask, 32'h80);
        idle();                        chk("t2_addr", rf_addr, 7);
        chk("t2_data", rf_data, 64'hABCD); chk("t2_mask_clr", pending_mask, 0);
        idle();                        chk("t2_we_off", rf_we, 0);

        // starvation guard
        step(1, 1, 64'h100, 1, 9, 64'h900); chk("t3_a0", a_ready, 1);
        for (int i = 1; i <= 4; i++) begin
            step(1, 1, 64'h100 + 64'(i), 0, 0, 0); chk("t3_a_win", a_ready, 1);
        end
        step(1, 1, 64'h105, 0, 0, 0);  chk("t3_forced", a_ready, 0);
        step(1, 1, 64'h105, 0, 0, 0);  chk("t3_resume", a_ready, 1);
        chk("t3_b_addr", rf_addr, 9);  chk("t3_b_data", rf_data, 64'h900);
        idle();                        chk("t3_a_data", rf_data, 64'h105);
        idle();

        // FIFO full back-pressure and ordering
        step(1, 2, 64'h22, 1, 10, 64'hA0); chk("t4_br0", b_ready, 1);
        step(1, 2, 64'h22, 1, 11, 64'hB0); chk("t4_br1", b_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 2, 64'h22, 1, 12, 64'hC0); chk("t4_full", b_ready, 0);
        end
        step(1, 2, 64'h22, 1, 12, 64'hC0); chk("t4_full_pop", b_ready, 0);
        chk("t4_forced", a_ready, 0);
        step(1, 2, 64'h22, 1, 12, 64'hC0); chk("t4_br_open", b_ready, 1);
        chk("t4_first", rf_addr, 10);
        idle();                        chk("t4_mask", pending_mask, 32'h1800);
        idle();                        chk("t4_second", rf_addr, 11);
        idle();                        chk("t4_third", rf_addr, 12);
        idle();                        chk("t4_drained", pending_mask, 0);

        // XZR destinations
        step(1, 31, 64'hFF, 0, 0, 0);  chk("t5_a_ready", a_ready, 1);
        step(0, 0, 0, 1, 31, 64'h31);  chk("t5_no_we", rf_we, 0);
        idle();                        chk("t5_mask", pending_mask, 0);
        idle();                        chk("t5_no_we_b", rf_we, 0);

        // reset mid-operation
        step(1, 4, 64'h44, 1, 13, 64'hD0);
        step(1, 4, 64'h45, 1, 14, 64'hE0);
        step(1, 4, 64'h46, 0, 0, 0);   chk("t6_mask_pre", pending_mask, 32'h6000);
        @(posedge clk); #1;
        reset = 1'b1; a_valid = 0; b_valid = 0;
        #1;
        chk("t6_we", rf_we, 0);        chk("t6_mask", pending_mask, 0);
        chk("t6_ar", a_ready, 0);      chk("t6_br", b_ready, 0);
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_br_after", b_ready, 1); chk("t6_mask_after", pending_mask, 0);

        // randomized traffic, A obeys hold-while-ungranted
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
            end
            if (!(a_valid && !m_grant_a)) begin
                a_valid = ($urandom_range(0, 99) < 55);
                a_reg   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                a_data  = {$urandom, $urandom};
            end
            b_valid = ($urandom_range(0, 99) < 40);
            b_reg   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            b_data  = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        reset = 1'b0; a_valid = 0; b_valid = 0;
        repeat (6) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
